// File: rtl/tp_pkg.sv
// tp_pkg: shared defaults and loader state encoding for the SPI memory loader.
package tp_pkg;
    localparam int DEF_WORD_W  = 8;
    localparam int DEF_IADDR_W = 4;
    localparam int DEF_DADDR_W = 4;
    typedef enum logic [1:0] {IDLE, LOAD_I, LOAD_D, HOLD} state_t;
endpackage

// File: rtl/spi_loader_sync2.sv
// sync2: two-flop synchronizer whose flops reset to a chosen value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
        else        {q, m} <= {m, d};
endmodule

// File: rtl/spi_loader.sv
// spi_loader: shifts serial words into instruction or data memory while the processor is halted.
module spi_loader
    import tp_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int IADDR_W = DEF_IADDR_W,
    parameter int DADDR_W = DEF_DADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               proc_en,
    input  logic               csi_n,
    input  logic               csd_n,
    input  logic               mosi,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0]  dmem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int CW = $clog2(WORD_W);
    logic ci, cd, mi;
    state_t state, nxt;
    logic [WORD_W-1:0] sr;
    logic [CW-1:0] cnt;
    logic both, shift, word, start, ses_end, wrote, pend;
    sync2 #(.RST_VAL(1'b1)) u_ci (.clk(clk), .rst_n(rst_n), .d(csi_n), .q(ci));
    sync2 #(.RST_VAL(1'b1)) u_cd (.clk(clk), .rst_n(rst_n), .d(csd_n), .q(cd));
    sync2 #(.RST_VAL(1'b0)) u_mi (.clk(clk), .rst_n(rst_n), .d(mosi),  .q(mi));
    // Shifting is keyed on the next state so the first bit lands in the cycle the select is seen.
    always_comb begin
        both    = !ci && !cd;
        nxt     = state;
        if (proc_en)    nxt = IDLE;
        else if (both)  nxt = HOLD;
        else case (state)
            IDLE:    nxt = !ci ? LOAD_I : !cd ? LOAD_D : IDLE;
            LOAD_I:  nxt = ci ? IDLE : LOAD_I;
            LOAD_D:  nxt = cd ? IDLE : LOAD_D;
            default: nxt = (ci && cd) ? IDLE : HOLD;
        endcase
        shift   = nxt == LOAD_I || nxt == LOAD_D;
        word    = shift && cnt == CW'(WORD_W - 1);
        start   = state == IDLE && shift;
        ses_end = (state == LOAD_I || state == LOAD_D) && nxt == IDLE && !proc_en;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            imem_we    <= 1'b0;
            dmem_we    <= 1'b0;
            imem_addr  <= '0;
            dmem_addr  <= '0;
            imem_wdata <= '0;
            dmem_wdata <= '0;
            wrote      <= 1'b0;
            pend       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= (shift && !word) ? cnt + 1'b1 : '0;
            if (shift) sr <= {sr[WORD_W-2:0], mi};
            imem_we <= word && nxt == LOAD_I;
            dmem_we <= word && nxt == LOAD_D;
            if (word && nxt == LOAD_I) imem_wdata <= {sr[WORD_W-2:0], mi};
            if (word && nxt == LOAD_D) dmem_wdata <= {sr[WORD_W-2:0], mi};
            if (start && nxt == LOAD_I) imem_addr <= '0;
            else if (imem_we)           imem_addr <= imem_addr + 1'b1;
            if (start && nxt == LOAD_D) dmem_addr <= '0;
            else if (dmem_we)           dmem_addr <= dmem_addr + 1'b1;
            err     <= err || both || (imem_we && &imem_addr) || (dmem_we && &dmem_addr);
            wrote   <= start ? 1'b0 : (wrote || imem_we || dmem_we);
            pend    <= ses_end && (wrote || imem_we || dmem_we);
            done    <= pend;
        end
    end
endmodule

// File: tb/tb_spi_loader.sv
// tb_spi_loader: scoreboard bench for spi_loader; expected writes are queued as words are sent.
module tb_spi_loader;
    logic       clk = 1'b0, rst_n = 1'b0, proc_en = 1'b0, csi_n = 1'b1, csd_n = 1'b1, mosi = 1'b0;
    logic       imem_we, dmem_we, busy, done, err;
    logic [3:0] imem_addr, dmem_addr;
    logic [7:0] imem_wdata, dmem_wdata;
    typedef struct {bit d; logic [3:0] a; logic [7:0] v;} wr_t;
    wr_t q[$];
    int errors = 0, checks = 0, done_cnt = 0;

    spi_loader dut (
        .clk(clk), .rst_n(rst_n), .proc_en(proc_en), .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    wr_t e;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (imem_we || dmem_we) begin
            chk("we_excl", 32'(imem_we && dmem_we), 0);
            if (q.size() == 0) chk("unexp_wr", 1, 0);
            else begin
                e = q.pop_front();
                chk("wr_mem", 32'(dmem_we), 32'(e.d));
                chk("wr_addr", imem_we ? imem_addr : dmem_addr, e.a);
                chk("wr_data", imem_we ? imem_wdata : dmem_wdata, e.v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int nbits = 8);
        for (int i = 7; i > 7 - nbits; i--) begin mosi = b[i]; tick(1); end
    endtask

    task automatic push(input bit d, input logic [3:0] a, input logic [7:0] v);
        wr_t w;
        w.d = d; w.a = a; w.v = v;
        q.push_back(w);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(3);
    endtask

    int d0;
    initial begin
        tick(2);
        chk("rst_outs", {imem_we, dmem_we, busy, done, err, imem_addr, dmem_addr}, 0);
        chk("rst_wdata", {imem_wdata, dmem_wdata}, 0);
        rst_n = 1'b1; tick(3);

        d0 = done_cnt;
        push(0, 0, 8'hA5); push(0, 1, 8'h3C);
        csi_n = 1'b0; send(8'hA5);
        chk("t1_busy", busy, 1);
        send(8'h3C); csi_n = 1'b1; tick(10);
        chk("t1_drained", q.size(), 0);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_idle", busy, 0);
        chk("t1_iaddr", imem_addr, 2);

        d0 = done_cnt;
        push(1, 0, 8'h81);
        csd_n = 1'b0; send(8'h81); send(8'hFF, 5); csd_n = 1'b1; tick(10);
        chk("t2_drained", q.size(), 0);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_daddr", dmem_addr, 1);
        chk("t2_iaddr_kept", imem_addr, 2);

        d0 = done_cnt;
        csi_n = 1'b0; csd_n = 1'b0; mosi = 1'b1; tick(10);
        chk("t3_busy", busy, 1);
        chk("t3_err", err, 1);
        csi_n = 1'b1; tick(4);
        chk("t3_hold", busy, 1);
        csd_n = 1'b1; tick(4);
        chk("t3_idle", busy, 0);
        chk("t3_err_sticky", err, 1);
        chk("t3_no_done", done_cnt - d0, 0);
        mosi = 1'b0;
        do_reset;
        chk("rst_err_clr", err, 0);

        d0 = done_cnt;
        for (int i = 0; i < 17; i++) push(0, 4'(i), 8'(i));
        csi_n = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 15) chk("t4_err_pre", err, 0);
            send(8'(i));
        end
        csi_n = 1'b1; tick(10);
        chk("t4_drained", q.size(), 0);
        chk("t4_err_wrap", err, 1);
        chk("t4_done", done_cnt - d0, 1);
        do_reset;

        d0 = done_cnt;
        csi_n = 1'b0; send(8'hF0, 4);
        chk("t5_busy", busy, 1);
        proc_en = 1'b1; tick(1);
        chk("t5_abort", busy, 0);
        send(8'hF0, 4); tick(2);
        csi_n = 1'b1; tick(6);
        proc_en = 1'b0; tick(4);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_idle", busy, 0);

        push(0, 0, 8'h5A);
        csi_n = 1'b0; send(8'h5A); send(8'hFF, 6);
        chk("t6_pre_addr", imem_addr, 1);
        chk("t6_pre_busy", busy, 1);
        rst_n = 1'b0; #1;
        chk("t6_rst_outs", {imem_we, dmem_we, busy, done, err, imem_addr, dmem_addr}, 0);
        chk("t6_rst_wdata", {imem_wdata, dmem_wdata}, 0);
        csi_n = 1'b1; tick(2); rst_n = 1'b1; tick(3);
        chk("t6_drained_pre", q.size(), 0);
        d0 = done_cnt;
        push(0, 0, 8'hC3);
        csi_n = 1'b0; send(8'hC3); csi_n = 1'b1; tick(10);
        chk("t6_drained", q.size(), 0);
        chk("t6_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_loader.md
SPI_LOADER -- requirements
Module: spi_loader

Interface
REQ-001 Parameter WORD_W, default 8, memory word width in bits.
REQ-002 Parameter IADDR_W, default 4, instruction-memory address width (16 words).
REQ-003 Parameter DADDR_W, default 4, data-memory address width (16 words).
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 proc_en  in  1  processor run enable; loader active only while low.
REQ-007 csi_n  in  1  active-low chip-select, instruction-memory load session.
REQ-008 csd_n  in  1  active-low chip-select, data-memory load session.
REQ-009 mosi  in  1  serial data, MSB first, one bit per clk while a select is low.
REQ-010 imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-011 imem_addr  out  IADDR_W  instruction-memory write address.
REQ-012 imem_wdata  out  WORD_W  instruction-memory write data.
REQ-013 dmem_we  out  1  data-memory write strobe, one cycle per word.
REQ-014 dmem_addr  out  DADDR_W  data-memory write address.
REQ-015 dmem_wdata  out  WORD_W  data-memory write data.
REQ-016 busy  out  1  high while a load session is open.
REQ-017 done  out  1  one-cycle pulse at end of a session that wrote at least one word.
REQ-018 err  out  1  sticky: both selects low together, or address wrap occurred.

Function
REQ-019 csi_n, csd_n, mosi SHALL pass through 2-flop synchronizers; all logic below uses synchronized values.
REQ-020 FSM states: IDLE, LOAD_I, LOAD_D, HOLD.
REQ-021 IDLE -> LOAD_I when proc_en=0, csi_n=0, csd_n=1; IDLE -> LOAD_D when proc_en=0, csd_n=0, csi_n=1.
REQ-022 Any state -> HOLD, err set, when csi_n=0 and csd_n=0 together; HOLD -> IDLE only when both high.
REQ-023 Any state -> IDLE, partial word discarded, no strobe, when proc_en=1.
REQ-024 In LOAD_x, each cycle shifts mosi into an 8-bit shift register (MSB first) and increments a 3-bit bit counter.
REQ-025 The cycle after the 8th bit is shifted, x_we=1 for exactly one cycle with x_wdata=assembled word, x_addr=current address.
REQ-026 Address increments the cycle after the strobe; from 2^ADDR_W-1 it wraps to 0 and sets err.
REQ-027 Sessions are back-to-back capable: bit 1 of the next word may be shifted in the strobe cycle.
REQ-028 Select deasserted mid-word: partial bits discarded, no strobe, state -> IDLE, bit counter cleared.
REQ-029 Select deasserted: done pulses one cycle after entering IDLE iff the session strobed >=1 word.
REQ-030 Each new session restarts its memory address at 0; the other memory's address is untouched.
REQ-031 busy=1 in LOAD_I, LOAD_D, HOLD; 0 in IDLE.
REQ-032 imem_we and dmem_we SHALL never be high in the same cycle.

Reset
REQ-033 rst_n low: state=IDLE, shift register, bit counter, both addresses, both wdata = 0; we, busy, done, err = 0.
REQ-034 Reset mid-session aborts without a strobe; synchronizers reset to 1 (selects deasserted), mosi flop to 0.
REQ-035 err clears only on reset.

Structure
REQ-036 Shared package tp_pkg holds WORD_W, IADDR_W, DADDR_W defaults and the loader state enum.
REQ-037 One sub-module, sync2, a reset-to-value 2-flop synchronizer instantiated per input.

Verification
REQ-038 proc_en=0, csi_n low, send 0xA5 then 0x3C -> imem_we at addr 0 data 0xA5, addr 1 data 0x3C; done pulse after csi_n high.
REQ-039 csd_n low, send 0x81, raise csd_n after 5 bits of 2nd word -> one dmem write (addr 0, 0x81), no 2nd strobe, done=1 once.
REQ-040 csi_n and csd_n low together -> no strobes, err=1, busy=1 until both high, then IDLE.
REQ-041 Load 17 instruction words 0x00..0x10 -> 17th write at addr 0 with data 0x10, err=1.
REQ-042 proc_en raised after 4 bits -> no strobe, busy=0 next cycle, no done.
REQ-043 rst_n pulsed low after 6 bits -> all outputs 0 immediately; new session writes addr 0.
